// File: rtl/timer_count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer sequencing core:
//   - bit positions of the fields inside the TCR control register
//   - clock-select encoding (cks_e) and its divide ratio
//   - sequencing FSM states (state_e)
// -----------------------------------------------------------------------------
package timer_pkg;

  // TCR field positions
  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // Prescaler clock select
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // Sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // Divide ratio selected by cks (2, 4, 8 or 16 pclk cycles per tick)
  function automatic logic [4:0] cks_ratio(input cks_e cks);
    case (cks)
      CKS_DIV2:  return 5'd2;
      CKS_DIV4:  return 5'd4;
      CKS_DIV8:  return 5'd8;
      default:   return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/timer_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_count_ctrl_if
// Connection between the APB register block (master) and the timer sequencing
// core (slave).
//   tdr_reg  reload value           (register block -> core)
//   tcr_reg  control register       (register block -> core)
//   tcnt     current counter value  (core -> register block)
//   s_ovf    up-wrap event pulse    (core -> register block)
//   s_udf    down-wrap event pulse  (core -> register block)
//   tick     applied prescaler tick (core -> register block)
// -----------------------------------------------------------------------------
interface timer_count_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdr_reg;
  logic [DATA_WIDTH-1:0] tcr_reg;
  logic [DATA_WIDTH-1:0] tcnt;
  logic                  s_ovf;
  logic                  s_udf;
  logic                  tick;

  modport master (
    output tdr_reg,
    output tcr_reg,
    input  tcnt,
    input  s_ovf,
    input  s_udf,
    input  tick
  );

  modport slave (
    input  tdr_reg,
    input  tcr_reg,
    output tcnt,
    output s_ovf,
    output s_udf,
    output tick
  );

endinterface

// File: rtl/timer_count_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides pclk by the ratio selected by cks and produces a one-cycle tick.
// Ports:
//   pclk    in   system clock, rising edge
//   preset  in   synchronous active-high reset
//   run     in   count enable (core is in S_RUN with en=1)
//   clear   in   force the divider back to 0 (load / leaving S_RUN)
//   cks     in   clock select
//   tick    out  combinational: divider at ratio-1 this cycle and not cleared
// The divider restarts from 0 whenever cks differs from its value in the
// previous cycle, so a new ratio always takes a full period to expire.
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_WIDTH = 4
) (
  input  logic pclk,
  input  logic preset,
  input  logic run,
  input  logic clear,
  input  cks_e cks,
  output logic tick
);

  logic [DIV_WIDTH-1:0] div_cnt_reg;
  cks_e                 cks_prev_reg;
  logic                 cks_changed;
  logic [DIV_WIDTH-1:0] div_last;

  assign cks_changed = (cks != cks_prev_reg);
  assign div_last    = DIV_WIDTH'(cks_ratio(cks) - 5'd1);

  // A cks change suppresses the tick of that cycle: the old count is meaningless
  // against the new terminal value.
  assign tick = run && !clear && !cks_changed && (div_cnt_reg == div_last);

  always_ff @(posedge pclk) begin
    if (preset) begin
      div_cnt_reg  <= '0;
      cks_prev_reg <= CKS_DIV2;
    end else begin
      cks_prev_reg <= cks;
      if (!run || clear || cks_changed || tick) begin
        div_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_count_ctrl.sv
// -----------------------------------------------------------------------------
// timer_count_ctrl
// Sequencing core of the timer: runs the prescaled up/down counter from the
// TDR/TCR values held by the register block and raises single-cycle wrap events.
// Ports:
//   pclk    in   system clock, rising edge
//   preset  in   synchronous active-high reset
//   bus     slave side of timer_count_ctrl_if
//             tdr_reg / tcr_reg in, tcnt / s_ovf / s_udf / tick out
// TCR: [7] load, [5] dir (0 up, 1 down), [4] en, [1:0] cks; other bits unused.
// All outputs are registered. s_ovf/s_udf/tick are high in the cycle in which
// tcnt shows the value produced by the corresponding step.
// -----------------------------------------------------------------------------
module timer_count_ctrl
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 4
) (
  input logic               pclk,
  input logic               preset,
  timer_count_ctrl_if.slave bus
);

  // Control field decode
  logic load;
  logic dir;
  logic en;
  cks_e cks;

  assign load = bus.tcr_reg[TCR_LOAD];
  assign dir  = bus.tcr_reg[TCR_DIR];
  assign en   = bus.tcr_reg[TCR_EN];
  assign cks  = cks_e'(bus.tcr_reg[TCR_CKS_HI:TCR_CKS_LO]);

  // Bits without a function in TCR
  logic unused_tcr_bits;
  assign unused_tcr_bits = ^{bus.tcr_reg[6], bus.tcr_reg[3:2]};

  // State and output registers
  state_e                state_reg;
  logic [DATA_WIDTH-1:0] tcnt_reg;
  logic                  ovf_reg;
  logic                  udf_reg;
  logic                  tick_reg;

  // Prescaler control
  logic in_run;
  logic leave_run;
  logic presc_run;
  logic presc_clear;
  logic presc_tick;

  assign in_run      = (state_reg == S_RUN);
  assign presc_run   = in_run && en;
  assign leave_run   = in_run && (load || !en);
  // Load always clears the divider, which also discards a coincident tick.
  assign presc_clear = load || leave_run;

  timer_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .pclk   (pclk),
    .preset (preset),
    .run    (presc_run),
    .clear  (presc_clear),
    .cks    (cks),
    .tick   (presc_tick)
  );

  // Next counter value and wrap detection
  logic [DATA_WIDTH-1:0] tcnt_next;
  logic                  ovf_next;
  logic                  udf_next;

  always_comb begin
    tcnt_next = tcnt_reg;
    ovf_next  = 1'b0;
    udf_next  = 1'b0;
    if (load) begin
      tcnt_next = bus.tdr_reg;
    end else if (presc_tick) begin
      if (dir) begin
        tcnt_next = tcnt_reg - 1'b1;
        udf_next  = (tcnt_reg == '0);
      end else begin
        tcnt_next = tcnt_reg + 1'b1;
        ovf_next  = (tcnt_reg == '1);
      end
    end
  end

  // FSM, counter and flag registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg <= S_IDLE;
      tcnt_reg  <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      ovf_reg  <= ovf_next;
      udf_reg  <= udf_next;
      tick_reg <= presc_tick;
      case (state_reg)
        S_IDLE: begin
          if (load) begin
            state_reg <= S_LOAD;
          end else if (en) begin
            state_reg <= S_RUN;
          end
        end
        S_LOAD: begin
          if (!load) begin
            state_reg <= en ? S_RUN : S_IDLE;
          end
        end
        S_RUN: begin
          if (load) begin
            state_reg <= S_LOAD;
          end else if (!en) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.tcnt  = tcnt_reg;
  assign bus.s_ovf = ovf_reg;
  assign bus.s_udf = udf_reg;
  assign bus.tick  = tick_reg;

endmodule

// File: tb/tb_timer_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_count_ctrl
// Directed stimulus for timer_count_ctrl. A behavioural model tracks the
// counter as "edges since the divider last restarted"; a compare process
// checks every cycle, and literal expectations pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_timer_count_ctrl;

  logic       pclk;
  logic       preset;
  logic [7:0] tdr;
  logic [7:0] tcr;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  timer_count_ctrl_if #(.DATA_WIDTH(8)) bus ();

  assign bus.tdr_reg = tdr;
  assign bus.tcr_reg = tcr;

  timer_count_ctrl #(
    .DATA_WIDTH (8),
    .DIV_WIDTH  (4)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  int m_tcnt, m_ovf, m_udf, m_tick, m_mode, m_phase, m_prev_cks;
  int m_ld, m_en, m_dn, m_ck, m_ratio;

  always @(posedge pclk) begin
    if (preset) begin
      m_tcnt = 0; m_ovf = 0; m_udf = 0; m_tick = 0;
      m_mode = M_IDLE; m_phase = 0; m_prev_cks = 0;
    end else begin
      m_ld    = int'(tcr[7]);
      m_en    = int'(tcr[4]);
      m_dn    = int'(tcr[5]);
      m_ck    = int'(tcr[1:0]);
      m_ratio = 2 << m_ck;
      m_ovf = 0; m_udf = 0; m_tick = 0;
      // Edges elapsed since the divider last restarted; a step happens when it reaches the ratio.
      if (m_mode == M_RUN && m_en == 1 && m_ld == 0 && m_ck == m_prev_cks)
        m_phase = m_phase + 1;
      else
        m_phase = 0;
      if (m_phase == m_ratio) begin
        m_phase = 0;
        m_tick  = 1;
        if (m_dn == 1) begin
          m_tcnt = (m_tcnt + 255) % 256;
          m_udf  = (m_tcnt == 255) ? 1 : 0;
        end else begin
          m_tcnt = (m_tcnt + 1) % 256;
          m_ovf  = (m_tcnt == 0) ? 1 : 0;
        end
      end
      if (m_ld == 1) m_tcnt = int'(tdr);
      // The transition table collapses to: load wins, else en selects run or idle.
      if (m_ld == 1)      m_mode = M_LOAD;
      else if (m_en == 1) m_mode = M_RUN;
      else                m_mode = M_IDLE;
      m_prev_cks = m_ck;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (cmp_en) begin
      chk("model_tcnt", int'(bus.tcnt),  m_tcnt);
      chk("model_ovf",  int'(bus.s_ovf), m_ovf);
      chk("model_udf",  int'(bus.s_udf), m_udf);
      chk("model_tick", int'(bus.tick),  m_tick);
    end
  end

  task automatic lit(input string nm, input logic [7:0] t, input logic o,
                     input logic u, input logic tk);
    $display("txn %s: tcnt=%02h ovf=%0b udf=%0b tick=%0b", nm, bus.tcnt,
             bus.s_ovf, bus.s_udf, bus.tick);
    chk({nm, "_tcnt"},  int'(bus.tcnt),  int'(t));
    chk({nm, "_ovf"},   int'(bus.s_ovf), int'(o));
    chk({nm, "_udf"},   int'(bus.s_udf), int'(u));
    chk({nm, "_tick"},  int'(bus.tick),  int'(tk));
    chk({nm, "_model"}, m_tcnt,          int'(t));
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  // Hand-computed sequences (one entry per cycle after the control write)
  logic [7:0] t2_cnt  [8]  = '{8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic       t2_ovf  [8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic       t2_tick [8]  = '{0, 0, 1, 0, 1, 0, 1, 0};
  logic [7:0] t3_cnt  [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
  logic       t3_udf  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic       t3_tick [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    preset = 1'b1;
    tcr    = 8'h10;
    tdr    = 8'h00;

    // 1: reset held for two edges
    repeat (2) step();
    lit("t1_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;

    // 2: load FD, count up /2 through the wrap
    preset = 1'b0; tdr = 8'hFD; tcr = 8'h80;
    step(); lit("t2_load", 8'hFD, 1'b0, 1'b0, 1'b0);
    tcr = 8'h10;
    for (int k = 0; k < 8; k++) begin
      step(); lit($sformatf("t2_c%0d", k), t2_cnt[k], t2_ovf[k], 1'b0, t2_tick[k]);
    end

    // 3: load 01, count down /4 through the wrap
    tdr = 8'h01; tcr = 8'h80;
    step(); lit("t3_load", 8'h01, 1'b0, 1'b0, 1'b0);
    tcr = 8'h31;
    for (int k = 0; k < 10; k++) begin
      step(); lit($sformatf("t3_c%0d", k), t3_cnt[k], 1'b0, t3_udf[k], t3_tick[k]);
    end

    // 4: load on the edge that would wrap FF -> 00
    tdr = 8'hFE; tcr = 8'h80;
    step(); lit("t4_load", 8'hFE, 1'b0, 1'b0, 1'b0);
    tcr = 8'h10;
    repeat (2) step();
    step(); lit("t4_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
    step();
    tdr = 8'h40; tcr = 8'h90;
    step(); lit("t4_loadwin", 8'h40, 1'b0, 1'b0, 1'b0);
    tcr = 8'h10;
    repeat (2) step();
    step(); lit("t4_resume", 8'h41, 1'b0, 1'b0, 1'b1);
    // ignored TCR bits set, tdr changed without load; then direction flip mid-run
    tcr = 8'h5C; tdr = 8'h77;
    repeat (6) step();
    lit("t4_ignored", 8'h44, 1'b0, 1'b0, 1'b1);
    tcr = 8'h3C;
    repeat (6) step();
    lit("t4_dirflip", 8'h41, 1'b0, 1'b0, 1'b1);

    // 5: /8 up, disable, re-enable, then change cks mid-run
    tdr = 8'h00; tcr = 8'h80;
    step(); lit("t5_load", 8'h00, 1'b0, 1'b0, 1'b0);
    tcr = 8'h12;
    repeat (8) step();
    step(); lit("t5_first", 8'h01, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    tcr = 8'h02;
    for (int k = 0; k < 5; k++) begin
      step(); lit($sformatf("t5_frozen%0d", k), 8'h01, 1'b0, 1'b0, 1'b0);
    end
    tcr = 8'h12;
    repeat (8) step();
    lit("t5_reen_early", 8'h01, 1'b0, 1'b0, 1'b0);
    step(); lit("t5_reen_tick", 8'h02, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    tcr = 8'h13;
    repeat (16) step();
    lit("t5_cks_early", 8'h02, 1'b0, 1'b0, 1'b0);
    step(); lit("t5_cks_tick", 8'h03, 1'b0, 1'b0, 1'b1);

    // 6: reset on the edge that would raise s_ovf
    tdr = 8'hFF; tcr = 8'h80;
    step(); lit("t6_load", 8'hFF, 1'b0, 1'b0, 1'b0);
    tcr = 8'h10;
    repeat (2) step();
    preset = 1'b1;
    step(); lit("t6_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    preset = 1'b0; tcr = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step(); lit($sformatf("t6_idle%0d", k), 8'h00, 1'b0, 1'b0, 1'b0);
    end
    tcr = 8'h10;
    repeat (2) step();
    step(); lit("t6_restart", 8'h01, 1'b0, 1'b0, 1'b1);

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
